alu_sequencer: RTL
==================

# alu_sequencer

Front-end controller for the team's sign-magnitude ALU. Accepts one operation request at a time over a valid/ready handshake and latches the operands. Single-pass ops (add, sub, shift left, shift right) go through one ALU evaluation. Multiply and divide are sequenced over N-1 iteration cycles. Result and Z/O/C/N flags are held in registers until the consumer takes them.

## Interface
- N, default 6, operand/result width in sign-magnitude form; MSB is the sign, N-1 magnitude bits (M = N-1).
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; equals (state==IDLE) and !rst.
- op  in  3  operation: 000 add, 001 sub, 010 mul, 011 div, 100 shl, 101 shr, 110/111 illegal.
- a, b  in  N  sign-magnitude operands, sampled on acceptance.
- rsp_valid  out  1  result/flags valid.
- rsp_ready  in  1  consumer takes response.
- result  out  N  sign-magnitude result.
- flags  out  4  {Z,O,C,N}: zero, overflow, carry, negative.
- err  out  1  illegal opcode or divide-by-zero.

## Operation
- Acceptance is req_valid && req_ready at a rising edge. On acceptance, op/a/b are latched; later input changes are ignored.
- State IDLE: on acceptance, single-pass, illegal, or div-by-zero → EXEC; mul or div with b magnitude ≠ 0 → ITER.
- State EXEC, one cycle, single-pass ops: the ALU is driven with sel=op and the latched operands; out/Z/O/C/N are registered into result/flags at the end of EXEC. Next state DONE.
- State EXEC, illegal op: result 0, flags 4'b1000, err 1.
- State EXEC, div-by-zero: result 0, flags 4'b1100, err 1.
- State ITER, mul: unsigned shift-add on the magnitudes for M cycles into a 2M-bit product.
  - Result magnitude = low M bits.
  - O = OR of the high M bits.
  - C = 0.
- State ITER, div: unsigned restoring division on the magnitudes for M cycles, producing the quotient; the remainder is discarded; O = 0, C = 0.
- State ITER, both: iteration counter of width $clog2(N), from 0 to M-1, then → DONE.
- Sign for mul/div = sign(a) XOR sign(b), forced to 0 when the result magnitude is 0 (no negative zero).
  - Z = (magnitude == 0).
  - N = result sign.
- State DONE: rsp_valid=1; result/flags/err are stable. On rsp_ready → IDLE. No new request is accepted in the same cycle.
- Shift ops: O = 0, C = 0, taken from the ALU.

## Timing
- Reset, asynchronous, effective immediately: state IDLE, rsp_valid 0, result 0, flags 0, err 0, counter 0, latched operands 0.
- Reset mid-operation aborts the operation; no response is produced.
- req_ready is 0 while rst is high and rises the first cycle after rst deasserts.
- Latency is counted from the acceptance edge k:
  - single-pass, illegal, div-by-zero: rsp_valid high after edge k+2;
  - mul/div: rsp_valid high after edge k+M+2 (after edge k+7 for N=6).
- Response handshake at edge j (rsp_valid && rsp_ready): rsp_valid low after j; req_ready high after j. The earliest next acceptance is edge j+1.
- Response hold: if rsp_ready stays low, rsp_valid and outputs hold indefinitely.
- Requests while busy: req_valid while not IDLE is not accepted and not queued.

## Structure
- Package alu_seq_pkg:
  - alu_op_t enum: OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010, OP_DIV=3'b011, OP_SHL=3'b100, OP_SHR=3'b101;
  - seq_state_t enum: IDLE, EXEC, ITER, DONE;
  - flag index constants FLAG_Z=3, FLAG_O=2, FLAG_C=1, FLAG_N=0.
- Sub-module mul_div_iter(N): magnitude shift-add / restoring-divide datapath with start, mode, done; the counter lives inside it.
- The sequencer instantiates the ALU for single-pass ops and mul_div_iter for mul/div.

## Test plan
All cases N=6.
- Add: a=000011, b=000010 → result 000101, flags 0000, err 0, rsp_valid after edge k+2.
- Multiply:
  - a=000101, b=100011 (5 × −3) → result 101111, flags 0001, rsp_valid after edge k+7;
  - a=000101, b=000111 (5 × 7) → result 000011, flags 0100.
- Divide:
  - a=001101, b=100100 (13 ÷ −4) → result 100011, flags 0001;
  - a=000010, b=100000 (divide by −0) → result 000000, flags 1100, err 1.
- Shifts and illegal op:
  - shl a=000011 → 000110;
  - shr a=000110 → 000011;
  - op=110 → result 0, flags 1000, err 1.
- Handshake:
  - hold rsp_ready low 5 cycles → outputs stable, req_ready 0, a second request not accepted;
  - release → next request accepted one cycle later.
- Reset: assert rst in the 3rd ITER cycle of a multiply → all outputs 0 immediately, no response; after release, an add completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and flag-index definitions for the ALU sequencer.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_SHL = 3'b100,
      OP_SHR = 3'b101
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      ITER,
      DONE
   } seq_state_t;

   localparam int FLAG_Z = 3;
   localparam int FLAG_O = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 0;

endpackage

// File: rtl/mul_div_iter.sv
// Magnitude datapath: shift-add multiply or restoring divide, one bit per cycle for M cycles.
module mul_div_iter #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start_i,
   input  logic         div_i,
   input  logic [N-2:0] a_i,
   input  logic [N-2:0] b_i,
   output logic [N-2:0] mag_o,
   output logic         ovf_o,
   output logic         done_o
);
   localparam int M  = N - 1;
   localparam int CW = $clog2(N);

   logic            div_q, busy_q, done_q;
   logic [CW-1:0]   cnt_q;
   logic [M-1:0]    opa_q, opb_q, quo_q, rem_q, rem_next;
   logic [2*M-1:0]  prod_q;
   logic [M:0]      add_s, shift_s;
   logic            ge;

   assign add_s    = {1'b0, prod_q[2*M-1:M]} + (prod_q[0] ? {1'b0, opa_q} : '0);
   assign shift_s  = {rem_q, quo_q[M-1]};
   assign ge       = shift_s >= {1'b0, opb_q};
   assign rem_next = ge ? (shift_s[M-1:0] - opb_q) : shift_s[M-1:0];

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
         opa_q  <= '0;
         opb_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         prod_q <= '0;
      end else if (start_i) begin
         div_q  <= div_i;
         opa_q  <= a_i;
         opb_q  <= b_i;
         prod_q <= {{M{1'b0}}, b_i};
         quo_q  <= a_i;
         rem_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
         done_q <= 1'b0;
      end else if (busy_q) begin
         if (div_q) begin
            rem_q <= rem_next;
            quo_q <= {quo_q[M-2:0], ge};
         end else begin
            prod_q <= {add_s, prod_q[M-1:1]};
         end
         cnt_q <= cnt_q + CW'(1);
         if (cnt_q == CW'(M - 1)) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
         end
      end
   end

   assign mag_o  = div_q ? quo_q : prod_q[M-1:0];
   assign ovf_o  = !div_q && (|prod_q[2*M-1:M]);
   assign done_o = done_q;

endmodule

// File: rtl/sm_alu.sv
// Single-pass sign-magnitude ALU: add, sub, shift left/right by one, with Z/O/C/N.
module sm_alu #(
   parameter int N = 6
) (
   input  logic [2:0]   sel_i,
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   output logic [N-1:0] out_o,
   output logic         z_o,
   output logic         o_o,
   output logic         c_o,
   output logic         n_o
);
   import alu_seq_pkg::*;

   localparam int M = N - 1;

   logic         sa, sb, sgn;
   logic [M-1:0] ma, mb, mag;
   logic [M:0]   sum;

   always_comb begin
      // NOTE: every output gets a default first, so no path can infer a latch.
      mag = '0;
      sgn = 1'b0;
      sum = '0;
      o_o = 1'b0;
      c_o = 1'b0;
      sa  = a_i[N-1];
      ma  = a_i[M-1:0];
      mb  = b_i[M-1:0];
      sb  = (sel_i == OP_SUB) ? ~b_i[N-1] : b_i[N-1];
      case (sel_i)
         OP_ADD, OP_SUB: begin
            if (sa == sb) begin
               sum = {1'b0, ma} + {1'b0, mb};
               mag = sum[M-1:0];
               sgn = sa;
               c_o = sum[M];
               o_o = sum[M];
            end else if (ma >= mb) begin
               mag = ma - mb;
               sgn = sa;
            end else begin
               mag = mb - ma;
               sgn = sb;
            end
         end
         OP_SHL: begin
            mag = {ma[M-2:0], 1'b0};
            sgn = sa;
         end
         OP_SHR: begin
            mag = {1'b0, ma[M-1:1]};
            sgn = sa;
         end
         default: ;
      endcase
      // A zero magnitude is always reported positive.
      n_o   = sgn & (mag != '0);
      z_o   = (mag == '0);
      out_o = {n_o, mag};
   end

endmodule

// File: rtl/alu_sequencer.sv
// Request/response front end: latches one op, runs it through the ALU or the
// mul/div iterator, and holds result and flags until the consumer takes them.
module alu_sequencer #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [N-1:0] result,
   output logic [3:0]   flags,
   output logic         err
);
   import alu_seq_pkg::*;

   localparam int M = N - 1;

   seq_state_t   state_q;
   logic [2:0]   op_q;
   logic [N-1:0] a_q, b_q, result_q;
   logic [3:0]   flags_q;
   logic         err_q, rsp_valid_q;

   logic         accept, to_iter;
   logic [N-1:0] alu_out, exec_result_d, iter_result_d;
   logic         alu_z, alu_o, alu_c, alu_n;
   logic [3:0]   exec_flags_d, iter_flags_d;
   logic         exec_err_d, iter_sign;
   logic [M-1:0] iter_mag;
   logic         iter_ovf, iter_done;

   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign to_iter   = (op == OP_MUL) || ((op == OP_DIV) && (b[M-1:0] != '0));

   sm_alu #(.N(N)) u_alu (
      .sel_i (op_q),
      .a_i   (a_q),
      .b_i   (b_q),
      .out_o (alu_out),
      .z_o   (alu_z),
      .o_o   (alu_o),
      .c_o   (alu_c),
      .n_o   (alu_n)
   );

   // The iterator loads straight from the request inputs on the acceptance edge.
   mul_div_iter #(.N(N)) u_iter (
      .clk     (clk),
      .rst     (rst),
      .start_i (accept && to_iter),
      .div_i   (op == OP_DIV),
      .a_i     (a[M-1:0]),
      .b_i     (b[M-1:0]),
      .mag_o   (iter_mag),
      .ovf_o   (iter_ovf),
      .done_o  (iter_done)
   );

   always_comb begin
      exec_result_d = alu_out;
      exec_flags_d  = {alu_z, alu_o, alu_c, alu_n};
      exec_err_d    = 1'b0;
      if (op_q[2:1] == 2'b11) begin
         exec_result_d         = '0;
         exec_flags_d          = '0;
         exec_flags_d[FLAG_Z]  = 1'b1;
         exec_err_d            = 1'b1;
      end else if (op_q == OP_DIV) begin
         exec_result_d         = '0;
         exec_flags_d          = '0;
         exec_flags_d[FLAG_Z]  = 1'b1;
         exec_flags_d[FLAG_O]  = 1'b1;
         exec_err_d            = 1'b1;
      end
   end

   always_comb begin
      iter_sign            = (a_q[N-1] ^ b_q[N-1]) && (iter_mag != '0);
      iter_result_d        = {iter_sign, iter_mag};
      iter_flags_d         = '0;
      iter_flags_d[FLAG_Z] = (iter_mag == '0);
      iter_flags_d[FLAG_O] = iter_ovf;
      iter_flags_d[FLAG_N] = iter_sign;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         flags_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= b;
                  state_q <= to_iter ? ITER : EXEC;
               end
            end
            EXEC: begin
               result_q <= exec_result_d;
               flags_q  <= exec_flags_d;
               err_q    <= exec_err_d;
               state_q  <= DONE;
            end
            ITER: begin
               if (iter_done) begin
                  result_q <= iter_result_d;
                  flags_q  <= iter_flags_d;
                  err_q    <= 1'b0;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle raises rsp_valid; the handshake then returns to IDLE.
               if (!rsp_valid_q) begin
                  rsp_valid_q <= 1'b1;
               end else if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign err       = err_q;

endmodule
